// File: rtl/fmul_pkg.sv
// Shared types and helpers for the iterative mantissa multiplier.
package fmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fmul_iter_state_t;

  localparam fmul_iter_state_t FMUL_RST_STATE = IDLE;

  function automatic int fmul_ndigits(input int bbits);
    return bbits / 4;
  endfunction

endpackage

// File: rtl/fmul_istage.sv
// One registered radix-2^mbits multiply step: {carry,result} <= a*m + carry_in.
module fmul_istage
  #(parameter int ibits       = 24,
    parameter int mbits       = 4,
    parameter bit async_reset = 1'b1,
    parameter int idx         = 0)
  (input  logic             i_clk,
   input  logic             i_nrst,
   input  logic [ibits-1:0] i_a,
   input  logic [mbits-1:0] i_m,
   input  logic [ibits-1:0] i_carry,
   input  logic             i_zres,
   output logic [mbits-1:0] o_result,
   output logic [ibits-1:0] o_carry);

  localparam int SW = ibits + mbits;

  if (idx < 0) begin : g_bad_idx
    $error("fmul_istage: idx must be non-negative");
  end

  // (2^ibits-1)*(2^mbits-1) + (2^ibits-1) < 2^SW, so the sum never overflows
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_nxt;
  logic [SW-1:0] r_sum;

  assign w_sum = SW'(i_a) * SW'(i_m) + SW'(i_carry);
  assign w_nxt = i_zres ? '0 : w_sum;

  if (async_reset) begin : g_areset
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) r_sum <= '0;
      else         r_sum <= w_nxt;
    end
  end else begin : g_sreset
    always_ff @(posedge i_clk) begin
      if (!i_nrst) r_sum <= '0;
      else         r_sum <= w_nxt;
    end
  end

  assign o_result = r_sum[mbits-1:0];
  assign o_carry  = r_sum[SW-1:mbits];

endmodule

// File: rtl/fmul_iter_ctrl.sv
// Iterative unsigned multiplier: walks B one nibble per cycle through a single
// fmul_istage, assembling the product LSB digit first.
module fmul_iter_ctrl
  import fmul_pkg::*;
  #(parameter int abits = 24,
    parameter int bbits = 24)
  (input  logic                   i_clk,
   input  logic                   i_nrst,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [abits-1:0]       i_a,
   input  logic [bbits-1:0]       i_b,
   input  logic                   i_flush,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [abits+bbits-1:0] o_res,
   output logic                   o_busy);

  localparam int ND = fmul_ndigits(bbits);
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  if ((bbits % 4) != 0 || ND < 2) begin : g_bad_bbits
    $error("fmul_iter_ctrl: bbits must be a multiple of 4 and at least 8");
  end

  typedef struct packed {
    fmul_iter_state_t       state;
    logic [CW-1:0]          cnt;
    logic [abits-1:0]       a;
    logic [bbits-1:0]       b;
    logic [abits+bbits-1:0] product;
  } regs_t;

  localparam regs_t REGS_RST = '{state: FMUL_RST_STATE, cnt: '0, a: '0, b: '0, product: '0};

  regs_t            r_q;
  regs_t            w_d;
  logic [3:0]       w_m;
  logic [abits-1:0] w_cin;
  logic [3:0]       w_res;
  logic [abits-1:0] w_carry;

  fmul_istage #(.ibits(abits), .mbits(4), .async_reset(1'b1), .idx(0)) u_stage (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_a      (r_q.a),
    .i_m      (w_m),
    .i_carry  (w_cin),
    .i_zres   (1'b0),
    .o_result (w_res),
    .o_carry  (w_carry)
  );

  always_comb begin : comb_proc
    w_d     = r_q;
    w_m     = '0;
    w_cin   = '0;
    o_ready = 1'b0;
    case (r_q.state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_d.state = MUL;
          w_d.cnt   = '0;
          w_d.a     = i_a;
          w_d.b     = i_b;
        end
      end
      MUL: begin
        w_m   = r_q.b[{r_q.cnt, 2'b00} +: 4];
        w_cin = (r_q.cnt == '0) ? '0 : w_carry;
        // stage output lags one cycle, so digit k-1 arrives while digit k is fed
        if (r_q.cnt != '0)
          w_d.product[bbits-1:0] = {w_res, r_q.product[bbits-1:4]};
        if (r_q.cnt == CW'(ND - 1)) begin
          w_d.state = DRAIN;
          w_d.cnt   = '0;
        end else begin
          w_d.cnt = r_q.cnt + 1'b1;
        end
      end
      DRAIN: begin
        w_d.product[bbits-1:0]           = {w_res, r_q.product[bbits-1:4]};
        w_d.product[abits+bbits-1:bbits] = w_carry;
        w_d.state                        = DONE;
      end
      DONE: begin
        if (i_ready) begin
          o_ready   = 1'b1;
          w_d.state = IDLE;
          if (i_valid) begin
            w_d.state = MUL;
            w_d.cnt   = '0;
            w_d.a     = i_a;
            w_d.b     = i_b;
          end
        end
      end
      default: w_d = REGS_RST;
    endcase
    if (i_flush) w_d = REGS_RST;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_q <= REGS_RST;
    else         r_q <= w_d;
  end

  assign o_valid = (r_q.state == DONE);
  assign o_busy  = (r_q.state != IDLE);
  assign o_res   = r_q.product;

endmodule
